nv_nvdla_csb_cfgrom_reqpipe: RTL and testbench
==============================================

// Module: nv_nvdla_csb_cfgrom_reqpipe
// PURPOSE
// - CSB-side stage directly upstream of the cfgrom slave. Registers CSB requests
//   into a 2-entry skid buffer and forwards them to cfgrom.
// - Tracks responses still owed: reads, and writes with nposted=1.
// - Registers cfgrom responses back to the CSB master.
// - Optional watchdog: when cfgrom stops answering, it injects an error response.
// PARAMETERS
// - MAX_OUTSTANDING  default 4    max owed responses; power of 2, 2..16
// - TIMEOUT_CYCLES   default 255  idle cycles with owed responses before error injection
// PORTS
// - nvdla_core_clk         in   1   core clock
// - nvdla_core_rst         in   1   reset, asynchronous, active-high
// - csb2pipe_req_pvld      in   1   upstream request valid
// - csb2pipe_req_prdy      out  1   upstream request ready
// - csb2pipe_req_pd        in   63  [21:0] addr, [53:22] wdat, [54] write, [55] nposted,
//                                   [56] srcpriv, [60:57] wrbe, [62:61] level
// - csb2cfgrom_req_pvld    out  1   request valid toward cfgrom
// - csb2cfgrom_req_prdy    in   1   cfgrom ready
// - csb2cfgrom_req_pd      out  63  request payload, unmodified
// - cfgrom2csb_resp_valid  in   1   cfgrom response valid (no backpressure)
// - cfgrom2csb_resp_pd     in   34  [31:0] rdata, [32] error, [33] type (0=read, 1=write)
// - pipe2csb_resp_valid    out  1   response valid to CSB master
// - pipe2csb_resp_pd       out  34  response payload
// - pipe_idle              out  1   skid empty and no owed responses
// - pipe_timeout_sticky    out  1   watchdog fired or stray response dropped; cleared by reset only
// BEHAVIOUR
// - Reset values: all outputs 0 except pipe_idle=1. Skid, counters and FIFO are empty.
//   Reset asserted mid-transaction discards everything; no response is replayed.
// - Ready rule: csb2pipe_req_prdy = (skid_cnt<2) && (resp_pend<MAX_OUTSTANDING).
//   - Registered state only; no combinational path from pd.
// - Accept: upstream fire pushes pd into skid.
//   - If the request expects a response (write==0 || nposted==1), resp_pend increments.
//   - With the macro enabled, the response type bit (=write) is also pushed into typeq.
// - Forward: csb2cfgrom_req_pvld = (skid_cnt!=0); pd = skid head.
//   - Pop on csb2cfgrom_req_pvld && csb2cfgrom_req_prdy.
//   - Minimum latency is 1 cycle (accept at N, visible at N+1).
//   - Order is preserved. Full throughput is sustained while cfgrom_prdy=1.
//   - pvld/pd stay stable until accepted.
// - Simultaneous push and pop: skid_cnt is unchanged.
// - Simultaneous accept and response: resp_pend is unchanged.
// - Response path: cfgrom response registered, 1 cycle latency.
//   - pipe2csb_resp_valid is a one-cycle pulse per response; pd is held until the next response.
//   - resp_pend decrements on each response and saturates at 0 (no underflow).
// - pipe_idle = (skid_cnt==0) && (resp_pend==0).
// CONFIGURATION
// - Macro NVDLA_CSB_CFGROM_TIMEOUT_EN.
// - Defined:
//   - typeq: 1-bit FIFO, MAX_OUTSTANDING deep; wptr/rptr wrap mod MAX_OUTSTANDING.
//   - Watchdog counter: reset on any cfgrom response or when resp_pend==0.
//     Otherwise it increments each cycle while resp_pend!=0.
//   - When the count reaches TIMEOUT_CYCLES, next cycle emits
//     pipe2csb_resp_pd={typeq head, 1'b1, 32'h0} with resp_valid=1.
//     The same event pops typeq, decrements resp_pend, clears the counter and sets the sticky flag.
//   - A real cfgrom response in the timeout cycle wins; no injection that cycle.
//   - A cfgrom response arriving with resp_pend==0 (late or stray) is dropped and sets the sticky flag.
// - Undefined:
//   - No typeq and no watchdog; pipe_timeout_sticky tied 0.
//   - Every cfgrom response is forwarded, including stray ones.
// TESTING
// - Read addr=0x000010, cfgrom_prdy=1, reply rdata=0x5A5A0001 two cycles later
//   -> req_pvld at N+1 with identical pd; pipe2csb_resp pd={0,0,0x5A5A0001} one cycle after input; pipe_idle returns 1.
// - Posted write (nposted=0) burst of 6, cfgrom_prdy=1
//   -> 6 requests forwarded back-to-back in order; no response; resp_pend stays 0; prdy never drops.
// - cfgrom_prdy=0 and 3 reads offered
//   -> 2 accepted, prdy=0 on the 3rd; head pd held stable.
//   Then cfgrom_prdy=1 -> 3rd accepted, all 3 forwarded in order.
// - MAX_OUTSTANDING=4, 5 reads, no responses
//   -> 5th read stalls with prdy=0 until one response returns, then accepted the next cycle.
// - Macro defined, TIMEOUT_CYCLES=8, nonposted write, no response
//   -> after 8 idle cycles pd={1,1,0x0}; sticky=1; pipe_idle=1.
//   A late cfgrom response is dropped and nothing is forwarded.
// - Assert reset with 2 skid entries and 2 owed responses
//   -> same cycle all outputs 0, pipe_idle=1; a subsequent cfgrom response is forwarded
//   (macro undefined) or dropped with sticky=1 (macro defined).

Source files
------------

// File: rtl/nv_nvdla_csb_cfgrom_reqpipe.sv
// -----------------------------------------------------------------------------
// nv_nvdla_csb_cfgrom_reqpipe
//
// Purpose:
//   CSB-side stage in front of the cfgrom slave. Incoming CSB requests are
//   captured in a 2-entry skid buffer and forwarded unmodified to cfgrom.
//   The stage counts responses still owed (reads and non-posted writes) and
//   registers every cfgrom response back to the CSB master.
//
// Optional feature (macro NVDLA_CSB_CFGROM_TIMEOUT_EN):
//   A watchdog injects an error response of the right type when cfgrom has
//   been silent for TIMEOUT_CYCLES cycles while responses are owed. Stray
//   responses (nothing owed) are dropped. Both events set pipe_timeout_sticky.
//   Without the macro, every cfgrom response is forwarded and the sticky flag
//   is tied low.
//
// Parameters:
//   MAX_OUTSTANDING  max owed responses (power of 2, 2..16)
//   TIMEOUT_CYCLES   silent cycles with owed responses before injection
//
// Ports:
//   nvdla_core_clk / nvdla_core_rst   clock, async active-high reset
//   csb2pipe_req_*                    upstream request (valid/ready/63b pd)
//   csb2cfgrom_req_*                  downstream request (valid/ready/63b pd)
//   cfgrom2csb_resp_*                 cfgrom response (valid/34b pd, no backpressure)
//   pipe2csb_resp_*                   registered response to CSB master
//   pipe_idle                         skid empty and nothing owed
//   pipe_timeout_sticky               watchdog fired or stray response dropped
// -----------------------------------------------------------------------------
module nv_nvdla_csb_cfgrom_reqpipe #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        csb2pipe_req_pvld,
  output logic        csb2pipe_req_prdy,
  input  logic [62:0] csb2pipe_req_pd,
  output logic        csb2cfgrom_req_pvld,
  input  logic        csb2cfgrom_req_prdy,
  output logic [62:0] csb2cfgrom_req_pd,
  input  logic        cfgrom2csb_resp_valid,
  input  logic [33:0] cfgrom2csb_resp_pd,
  output logic        pipe2csb_resp_valid,
  output logic [33:0] pipe2csb_resp_pd,
  output logic        pipe_idle,
  output logic        pipe_timeout_sticky
);

  localparam int PW = $clog2(MAX_OUTSTANDING) + 1;

  // An illegal parameter set keeps the request port closed forever rather
  // than letting the pointer/counter arithmetic misbehave.
  localparam bit CFG_OK = (MAX_OUTSTANDING >= 2) && (MAX_OUTSTANDING <= 16) &&
                          ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) == 0) &&
                          (TIMEOUT_CYCLES >= 1);

  // Skid buffer
  logic [62:0]   skid_q [2];
  logic [62:0]   skid_d [2];
  logic          skid_wptr_q, skid_wptr_d;
  logic          skid_rptr_q, skid_rptr_d;
  logic [1:0]    skid_cnt_q, skid_cnt_d;

  // Owed-response counter
  logic [PW-1:0] resp_pend_q, resp_pend_d;

  // Ready is held low for the first cycle after reset so every output is 0
  // while reset is applied.
  logic          rdy_en_q, rdy_en_d;

  // Response register
  logic          resp_valid_q, resp_valid_d;
  logic [33:0]   resp_pd_q, resp_pd_d;

  logic          req_fire;
  logic          fwd_fire;
  logic          need_resp;
  logic          pend_inc;
  logic          pend_dec;
  logic          pend_nz;
  logic          wd_fire;

  assign rdy_en_d  = CFG_OK;
  assign pend_nz   = (resp_pend_q != '0);

  assign csb2pipe_req_prdy   = rdy_en_q && (skid_cnt_q < 2'd2) &&
                               (resp_pend_q < PW'(MAX_OUTSTANDING));
  assign csb2cfgrom_req_pvld = (skid_cnt_q != 2'd0);
  assign csb2cfgrom_req_pd   = skid_q[skid_rptr_q];

  assign req_fire  = csb2pipe_req_pvld && csb2pipe_req_prdy;
  assign fwd_fire  = csb2cfgrom_req_pvld && csb2cfgrom_req_prdy;
  // Reads and non-posted writes get a response.
  assign need_resp = !csb2pipe_req_pd[54] || csb2pipe_req_pd[55];
  assign pend_inc  = req_fire && need_resp;
  // A response with nothing owed never decrements (saturation at 0).
  assign pend_dec  = (cfgrom2csb_resp_valid && pend_nz) || wd_fire;

  assign pipe2csb_resp_valid = resp_valid_q;
  assign pipe2csb_resp_pd    = resp_pd_q;
  assign pipe_idle           = (skid_cnt_q == 2'd0) && !pend_nz;

  always_comb begin
    skid_d      = skid_q;
    skid_wptr_d = skid_wptr_q ^ req_fire;
    skid_rptr_d = skid_rptr_q ^ fwd_fire;
    skid_cnt_d  = skid_cnt_q;
    if (req_fire) begin
      skid_d[skid_wptr_q] = csb2pipe_req_pd;
    end
    unique case ({req_fire, fwd_fire})
      2'b10:   skid_cnt_d = skid_cnt_q + 2'd1;
      2'b01:   skid_cnt_d = skid_cnt_q - 2'd1;
      default: skid_cnt_d = skid_cnt_q;
    endcase
  end

  always_comb begin
    resp_pend_d = resp_pend_q;
    unique case ({pend_inc, pend_dec})
      2'b10:   resp_pend_d = resp_pend_q + PW'(1);
      2'b01:   resp_pend_d = resp_pend_q - PW'(1);
      default: resp_pend_d = resp_pend_q;
    endcase
  end

`ifdef NVDLA_CSB_CFGROM_TIMEOUT_EN
  localparam int QW = $clog2(MAX_OUTSTANDING);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // typeq remembers the response type (0=read, 1=write) of each owed
  // response so an injected error carries the right type.
  logic [MAX_OUTSTANDING-1:0] typeq_q, typeq_d;
  logic [QW-1:0]              tq_wptr_q, tq_wptr_d;
  logic [QW-1:0]              tq_rptr_q, tq_rptr_d;
  logic [TW-1:0]              wd_cnt_q, wd_cnt_d;
  logic                       sticky_q, sticky_d;

  // A real response in the same cycle wins over injection.
  assign wd_fire = (wd_cnt_q == TW'(TIMEOUT_CYCLES)) && !cfgrom2csb_resp_valid && pend_nz;
  assign pipe_timeout_sticky = sticky_q;

  always_comb begin
    typeq_d   = typeq_q;
    tq_wptr_d = tq_wptr_q;
    tq_rptr_d = tq_rptr_q;
    if (pend_inc) begin
      typeq_d[tq_wptr_q] = csb2pipe_req_pd[54];
      tq_wptr_d          = tq_wptr_q + QW'(1);
    end
    if (pend_dec) begin
      tq_rptr_d = tq_rptr_q + QW'(1);
    end

    if (cfgrom2csb_resp_valid || !pend_nz || wd_fire) begin
      wd_cnt_d = '0;
    end else begin
      wd_cnt_d = wd_cnt_q + TW'(1);
    end

    sticky_d = sticky_q || wd_fire || (cfgrom2csb_resp_valid && !pend_nz);

    resp_valid_d = 1'b0;
    resp_pd_d    = resp_pd_q;
    if (cfgrom2csb_resp_valid && pend_nz) begin
      resp_valid_d = 1'b1;
      resp_pd_d    = cfgrom2csb_resp_pd;
    end else if (wd_fire) begin
      resp_valid_d = 1'b1;
      resp_pd_d    = {typeq_q[tq_rptr_q], 1'b1, 32'h0};
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      typeq_q   <= '0;
      tq_wptr_q <= '0;
      tq_rptr_q <= '0;
      wd_cnt_q  <= '0;
      sticky_q  <= 1'b0;
    end else begin
      typeq_q   <= typeq_d;
      tq_wptr_q <= tq_wptr_d;
      tq_rptr_q <= tq_rptr_d;
      wd_cnt_q  <= wd_cnt_d;
      sticky_q  <= sticky_d;
    end
  end
`else
  assign wd_fire             = 1'b0;
  assign pipe_timeout_sticky = 1'b0;

  always_comb begin
    resp_valid_d = cfgrom2csb_resp_valid;
    resp_pd_d    = cfgrom2csb_resp_valid ? cfgrom2csb_resp_pd : resp_pd_q;
  end
`endif

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      for (int i = 0; i < 2; i++) begin
        skid_q[i] <= '0;
      end
      skid_wptr_q  <= 1'b0;
      skid_rptr_q  <= 1'b0;
      skid_cnt_q   <= 2'd0;
      resp_pend_q  <= '0;
      rdy_en_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_pd_q    <= '0;
    end else begin
      skid_q       <= skid_d;
      skid_wptr_q  <= skid_wptr_d;
      skid_rptr_q  <= skid_rptr_d;
      skid_cnt_q   <= skid_cnt_d;
      resp_pend_q  <= resp_pend_d;
      rdy_en_q     <= rdy_en_d;
      resp_valid_q <= resp_valid_d;
      resp_pd_q    <= resp_pd_d;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_csb_cfgrom_reqpipe.sv
// Directed bench for nv_nvdla_csb_cfgrom_reqpipe (MAX_OUTSTANDING=4,
// TIMEOUT_CYCLES=8). Inputs change 1ns after a rising edge; outputs are
// sampled there too, i.e. they reflect the state registered at that edge.
module tb_nv_nvdla_csb_cfgrom_reqpipe;

  logic        clk;
  logic        rst;
  logic        req_pvld;
  logic        req_prdy;
  logic [62:0] req_pd;
  logic        fwd_pvld;
  logic        fwd_prdy;
  logic [62:0] fwd_pd;
  logic        rin_valid;
  logic [33:0] rin_pd;
  logic        rout_valid;
  logic [33:0] rout_pd;
  logic        idle;
  logic        sticky;

  int checks = 0;
  int errors = 0;

  nv_nvdla_csb_cfgrom_reqpipe #(
    .MAX_OUTSTANDING(4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .nvdla_core_clk       (clk),
    .nvdla_core_rst       (rst),
    .csb2pipe_req_pvld    (req_pvld),
    .csb2pipe_req_prdy    (req_prdy),
    .csb2pipe_req_pd      (req_pd),
    .csb2cfgrom_req_pvld  (fwd_pvld),
    .csb2cfgrom_req_prdy  (fwd_prdy),
    .csb2cfgrom_req_pd    (fwd_pd),
    .cfgrom2csb_resp_valid(rin_valid),
    .cfgrom2csb_resp_pd   (rin_pd),
    .pipe2csb_resp_valid  (rout_valid),
    .pipe2csb_resp_pd     (rout_pd),
    .pipe_idle            (idle),
    .pipe_timeout_sticky  (sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {level, wrbe, srcpriv, nposted, write, wdat, addr}
  function automatic logic [62:0] mk_req(input logic [21:0] addr, input logic [31:0] wdat,
                                         input logic wr, input logic np);
    return {2'b00, 4'hF, 1'b0, np, wr, wdat, addr};
  endfunction

  logic [62:0] ra, rb, rc;
  logic [62:0] burst [6];
  logic [62:0] rd4 [5];
  int          n;

  initial begin
    rst = 1'b1; req_pvld = 1'b0; req_pd = '0; fwd_prdy = 1'b0;
    rin_valid = 1'b0; rin_pd = '0;
    tick(); tick();
    chk("rst_prdy", 64'(req_prdy), 64'd0);
    chk("rst_fwd_pvld", 64'(fwd_pvld), 64'd0);
    chk("rst_fwd_pd", 64'(fwd_pd), 64'd0);
    chk("rst_resp_valid", 64'(rout_valid), 64'd0);
    chk("rst_resp_pd", 64'(rout_pd), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_sticky", 64'(sticky), 64'd0);
    $display("T0 reset state checked");
    rst = 1'b0;
    tick();
    chk("post_rst_prdy", 64'(req_prdy), 64'd1);

    // ---- single read, reply two cycles later ----
    ra = mk_req(22'h000010, 32'h0, 1'b0, 1'b0);
    fwd_prdy = 1'b1; req_pvld = 1'b1; req_pd = ra;
    chk("t1_prdy", 64'(req_prdy), 64'd1);
    tick();
    req_pvld = 1'b0;
    chk("t1_fwd_pvld", 64'(fwd_pvld), 64'd1);
    chk("t1_fwd_pd", 64'(fwd_pd), 64'(ra));
    chk("t1_idle_busy", 64'(idle), 64'd0);
    rin_valid = 1'b1; rin_pd = {1'b0, 1'b0, 32'h5A5A0001};
    tick();
    rin_valid = 1'b0;
    chk("t1_resp_valid", 64'(rout_valid), 64'd1);
    chk("t1_resp_pd", 64'(rout_pd), 64'h05A5A0001);
    chk("t1_idle", 64'(idle), 64'd1);
    tick();
    chk("t1_resp_pulse", 64'(rout_valid), 64'd0);
    chk("t1_resp_hold", 64'(rout_pd), 64'h05A5A0001);
    $display("T1 single read done");

    // ---- posted write burst of 6 ----
    for (int i = 0; i < 6; i++) begin
      burst[i] = mk_req(22'(32'h100 + i), 32'hC0DE0000 + 32'(i), 1'b1, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      req_pvld = 1'b1; req_pd = burst[i];
      chk($sformatf("t2_prdy_%0d", i), 64'(req_prdy), 64'd1);
      tick();
      chk($sformatf("t2_fwd_pd_%0d", i), 64'(fwd_pd), 64'(burst[i]));
      chk($sformatf("t2_rvalid_%0d", i), 64'(rout_valid), 64'd0);
    end
    req_pvld = 1'b0;
    tick();
    chk("t2_drained", 64'(fwd_pvld), 64'd0);
    chk("t2_idle", 64'(idle), 64'd1);
    $display("T2 posted burst done");

    // ---- backpressure: 3 reads with cfgrom stalled ----
    ra = mk_req(22'h000200, 32'h0, 1'b0, 1'b0);
    rb = mk_req(22'h000204, 32'h0, 1'b0, 1'b0);
    rc = mk_req(22'h000208, 32'h0, 1'b0, 1'b0);
    fwd_prdy = 1'b0;
    req_pvld = 1'b1; req_pd = ra;
    chk("t3_prdy_a", 64'(req_prdy), 64'd1);
    tick();
    req_pd = rb;
    chk("t3_prdy_b", 64'(req_prdy), 64'd1);
    tick();
    req_pd = rc;
    chk("t3_prdy_c_stall", 64'(req_prdy), 64'd0);
    chk("t3_head_a", 64'(fwd_pd), 64'(ra));
    tick();
    chk("t3_prdy_c_stall2", 64'(req_prdy), 64'd0);
    chk("t3_head_a_stable", 64'(fwd_pd), 64'(ra));
    fwd_prdy = 1'b1;
    tick();
    chk("t3_head_b", 64'(fwd_pd), 64'(rb));
    chk("t3_prdy_c", 64'(req_prdy), 64'd1);
    tick();
    req_pvld = 1'b0;
    chk("t3_head_c", 64'(fwd_pd), 64'(rc));
    tick();
    chk("t3_drained", 64'(fwd_pvld), 64'd0);
    chk("t3_idle_owed", 64'(idle), 64'd0);
    for (int i = 0; i < 3; i++) begin
      rin_valid = 1'b1; rin_pd = {2'b00, 32'h11110000 + 32'(i)};
      tick();
      chk($sformatf("t3_resp_v_%0d", i), 64'(rout_valid), 64'd1);
      chk($sformatf("t3_resp_pd_%0d", i), 64'(rout_pd), 64'({2'b00, 32'h11110000 + 32'(i)}));
    end
    rin_valid = 1'b0;
    tick();
    chk("t3_idle", 64'(idle), 64'd1);
    $display("T3 backpressure done");

    // ---- outstanding limit: 5 reads, no responses ----
    for (int i = 0; i < 5; i++) begin
      rd4[i] = mk_req(22'(32'h300 + 4 * i), 32'h0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      req_pvld = 1'b1; req_pd = rd4[i];
      chk($sformatf("t4_prdy_%0d", i), 64'(req_prdy), 64'd1);
      tick();
    end
    req_pd = rd4[4];
    chk("t4_prdy_full", 64'(req_prdy), 64'd0);
    tick();
    chk("t4_prdy_full2", 64'(req_prdy), 64'd0);
    chk("t4_skid_empty", 64'(fwd_pvld), 64'd0);
    rin_valid = 1'b1; rin_pd = {2'b00, 32'hABCD0000};
    tick();
    rin_valid = 1'b0;
    chk("t4_resp_v", 64'(rout_valid), 64'd1);
    chk("t4_prdy_reopen", 64'(req_prdy), 64'd1);
    tick();
    req_pvld = 1'b0;
    chk("t4_fwd_pvld5", 64'(fwd_pvld), 64'd1);
    chk("t4_fwd_pd5", 64'(fwd_pd), 64'(rd4[4]));
    chk("t4_prdy_full3", 64'(req_prdy), 64'd0);
    $display("T4 outstanding limit done");

    // ---- reset with owed responses, then reset with 2 skid entries + 2 owed ----
    rst = 1'b1;
    #1;
    chk("t5a_fwd_pvld", 64'(fwd_pvld), 64'd0);
    chk("t5a_idle", 64'(idle), 64'd1);
    tick();
    rst = 1'b0;
    tick();
    fwd_prdy = 1'b0;
    req_pvld = 1'b1; req_pd = ra;
    tick();
    req_pd = rb;
    tick();
    req_pvld = 1'b0;
    chk("t5_prdy_full", 64'(req_prdy), 64'd0);
    chk("t5_head", 64'(fwd_pd), 64'(ra));
    rst = 1'b1;
    #1;
    chk("t5_rst_prdy", 64'(req_prdy), 64'd0);
    chk("t5_rst_fwd_pvld", 64'(fwd_pvld), 64'd0);
    chk("t5_rst_fwd_pd", 64'(fwd_pd), 64'd0);
    chk("t5_rst_rvalid", 64'(rout_valid), 64'd0);
    chk("t5_rst_rpd", 64'(rout_pd), 64'd0);
    chk("t5_rst_idle", 64'(idle), 64'd1);
    chk("t5_rst_sticky", 64'(sticky), 64'd0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("t5_no_replay", 64'(rout_valid), 64'd0);
    rin_valid = 1'b1; rin_pd = {1'b1, 1'b0, 32'hDEADBEEF};
    tick();
    rin_valid = 1'b0;
`ifdef NVDLA_CSB_CFGROM_TIMEOUT_EN
    chk("t5_stray_dropped", 64'(rout_valid), 64'd0);
    chk("t5_stray_sticky", 64'(sticky), 64'd1);
`else
    chk("t5_stray_fwd", 64'(rout_valid), 64'd1);
    chk("t5_stray_pd", 64'(rout_pd), 64'h2DEADBEEF);
    chk("t5_stray_sticky", 64'(sticky), 64'd0);
`endif
    chk("t5_idle", 64'(idle), 64'd1);
    $display("T5 reset discard done");

`ifdef NVDLA_CSB_CFGROM_TIMEOUT_EN
    // ---- watchdog: non-posted write, cfgrom never answers ----
    rst = 1'b1; tick(); rst = 1'b0; tick();
    fwd_prdy = 1'b1;
    req_pvld = 1'b1; req_pd = mk_req(22'h000400, 32'h12345678, 1'b1, 1'b1);
    tick();
    req_pvld = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (rout_valid && n == 0) n = i;
    end
    chk("t6_inject_latency", 64'(n), 64'd9);
    chk("t6_inject_pd", 64'(rout_pd), 64'h300000000);
    chk("t6_sticky", 64'(sticky), 64'd1);
    chk("t6_idle", 64'(idle), 64'd1);
    rin_valid = 1'b1; rin_pd = {2'b10, 32'h0};
    tick();
    rin_valid = 1'b0;
    chk("t6_late_dropped", 64'(rout_valid), 64'd0);
    $display("T6 watchdog done");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
